multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the 16-bit RISC-V core. It sequences the shared datapath (ALU, register file, single unified memory port, PC) through FETCH/DECODE/EXEC/MEM/WB.
- It replaces single-cycle control decoding with per-state strobes and a ready-based memory handshake.
- It sits between the instruction register/opcode fields and the datapath muxes and enables.

---
 rtl/core_ctrl_pkg.sv | 58 +++++
 rtl/instr_class_decode.sv | 25 ++
 rtl/multicycle_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared encodings for the multi-cycle core control path
package core_ctrl_pkg;

    // Sequencer states; the numeric values are what state_o exposes for debug.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // Instruction classes the sequencer distinguishes.
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_IALU   = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JAL    = 3'd6
    } instr_class_e;

    // Major opcodes (IR[6:0]).
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // PC source mux select.
    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // Register write-back mux select.
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    // Trap causes.
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // ALU operations the sequencer forces itself.
    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_CMP = 3'b001;

    // Classes whose EXEC step computes an address and then visits MEM.
    function automatic logic is_mem_class(input instr_class_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// rtl/instr_class_decode.sv - combinational opcode to instruction-class mapper
module instr_class_decode
    import core_ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output instr_class_e cls_o,
    output logic         illegal_o
);

    // Map each supported major opcode to its class; anything else is illegal.
    always_comb begin
        cls_o     = CLS_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_RTYPE:  cls_o = CLS_RTYPE;
            OPC_IALU:   cls_o = CLS_IALU;
            OPC_LOAD:   cls_o = CLS_LOAD;
            OPC_STORE:  cls_o = CLS_STORE;
            OPC_BRANCH: cls_o = CLS_BRANCH;
            OPC_JAL:    cls_o = CLS_JAL;
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit core
module multicycle_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_BYTES = 2,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_src,
    output logic       ir_load,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state_o
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    state_e          state_q;
    instr_class_e    cls_q;
    logic [TO_W-1:0] wait_q;
    logic [1:0]      cause_q;

    instr_class_e    dec_cls;
    logic            dec_illegal;
    logic            mem_timeout;

    // The PC increment and link value are formed in the datapath; the
    // sequencer only selects them, so INSTR_BYTES carries no logic here.
    logic unused_instr_bytes;
    assign unused_instr_bytes = (INSTR_BYTES == 0);

    instr_class_decode u_decode (
        .opcode_i  (opcode),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    // A pending request has waited its full budget and memory is still not ready.
    assign mem_timeout = !mem_ready && (wait_q == TO_LIMIT);

    // Sequencer state, latched class, wait counter and trap cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NONE;
            wait_q  <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wait_q <= '0;
                    if (run) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        wait_q  <= '0;
                        state_q <= ST_DECODE;
                    end else if (mem_timeout) begin
                        wait_q  <= '0;
                        cause_q <= CAUSE_TIMEOUT;
                        state_q <= ST_TRAP;
                    end else begin
                        wait_q <= wait_q + TO_ONE;
                    end
                end
                ST_DECODE: begin
                    wait_q <= '0;
                    cls_q  <= dec_cls;
                    if (dec_illegal) begin
                        cause_q <= CAUSE_ILLEGAL;
                        state_q <= ST_TRAP;
                    end else if (dec_cls == CLS_JAL) begin
                        state_q <= ST_WB;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wait_q <= '0;
                    if (is_mem_class(cls_q)) begin
                        state_q <= ST_MEM;
                    end else if (cls_q == CLS_RTYPE || cls_q == CLS_IALU) begin
                        state_q <= ST_WB;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        wait_q  <= '0;
                        state_q <= (cls_q == CLS_LOAD) ? ST_WB : ST_IDLE;
                    end else if (mem_timeout) begin
                        wait_q  <= '0;
                        cause_q <= CAUSE_TIMEOUT;
                        state_q <= ST_TRAP;
                    end else begin
                        wait_q <= wait_q + TO_ONE;
                    end
                end
                ST_WB: begin
                    wait_q  <= '0;
                    state_q <= ST_IDLE;
                end
                ST_TRAP: begin
                    wait_q <= '0;
                end
                default: begin
                    wait_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-state datapath strobes; completion strobes follow mem_ready directly.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        alu_src    = 1'b0;
        alu_op     = ALU_OP_ADD;
        reg_write  = 1'b0;
        wb_sel     = WB_SEL_ALU;
        instr_done = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_RTYPE: begin
                        alu_op = funct3;
                    end
                    CLS_IALU: begin
                        alu_src = 1'b1;
                        alu_op  = funct3;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src = 1'b1;
                    end
                    CLS_BRANCH: begin
                        alu_op     = ALU_OP_CMP;
                        instr_done = 1'b1;
                        if (branch_taken) begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_BRANCH;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                mem_we   = (cls_q == CLS_STORE);
                if (mem_ready && cls_q == CLS_STORE) begin
                    instr_done = 1'b1;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                case (cls_q)
                    CLS_LOAD: wb_sel = WB_SEL_MEM;
                    CLS_JAL: begin
                        wb_sel   = WB_SEL_LINK;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                    end
                    default:  wb_sel = WB_SEL_ALU;
                endcase
            end
            default: ;
        endcase
    end

    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;
    import core_ctrl_pkg::*;

    localparam int TB_TIMEOUT = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asrc;
        logic       irl;
        logic       pcw;
        logic [1:0] pcs;
        logic       alus;
        logic [2:0] aop;
        logic       rw;
        logic [1:0] wbs;
        logic       done;
        logic       trp;
        logic [1:0] cause;
    } out_t;

    typedef struct {
        logic       run;
        logic       rdy;
        logic       bt;
        logic [6:0] op;
        logic [2:0] f3;
        out_t       exp;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       bt;
        int         flat;
        int         mlat;
        int         len;
        logic       trp;
        logic [1:0] cause;
    } vec_t;

    logic       clk, rst, run, mem_ready, branch_taken;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_req, mem_we, addr_src, ir_load, pc_write, alu_src, reg_write;
    logic       instr_done, trap;
    logic [1:0] pc_src, wb_sel, trap_cause;
    logic [2:0] alu_op, state_o;
    out_t       dut_out;

    int   n_tests, n_fail;
    cyc_t tq[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    vec_t tbl[15];

    multicycle_sequencer #(.INSTR_BYTES(2), .MEM_TIMEOUT(TB_TIMEOUT), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_load(ir_load),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
    );

    assign dut_out = {state_o, mem_req, mem_we, addr_src, ir_load, pc_write, pc_src,
                      alu_src, alu_op, reg_write, wb_sel, instr_done, trap, trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t zo(input logic [2:0] st);
        out_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    task automatic check_out(input string name, input int idx, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_cyc(input logic r, input logic rdy, input logic b, input out_t e);
        cyc_t c;
        c.run = r; c.rdy = rdy; c.bt = b; c.op = cur_op; c.f3 = cur_f3; c.exp = e;
        tq.push_back(c);
    endtask

    // Once trapped the core ignores run and memory until reset.
    task automatic add_trap(input logic [1:0] cause);
        out_t e;
        e = zo(ST_TRAP);
        e.trp = 1'b1;
        e.cause = cause;
        for (int i = 0; i < 6; i++) add_cyc(1'b1, rb(), rb(), e);
    endtask

    // A memory request that completes after lat not-ready cycles, or traps
    // once it has already waited the full timeout budget.
    task automatic wait_mem(input logic [2:0] st, input logic we, input logic asrc,
                            input int lat, input out_t fin, output bit ok);
        out_t e;
        ok = 1'b0;
        for (int i = 0; i <= TB_TIMEOUT; i++) begin
            e = zo(st);
            e.req = 1'b1; e.we = we; e.asrc = asrc;
            if (i == lat) begin
                e = out_t'(e | fin);
                add_cyc(rb(), 1'b1, rb(), e);
                ok = 1'b1;
                break;
            end
            add_cyc(rb(), 1'b0, rb(), e);
            if (i == TB_TIMEOUT) add_trap(CAUSE_TIMEOUT);
        end
    endtask

    task automatic add_gap(input int n);
        for (int i = 0; i < n; i++) add_cyc(1'b0, rb(), rb(), zo(ST_IDLE));
    endtask

    // Expected cycle-by-cycle behaviour of one instruction.
    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic bt,
                             input int flat, input int mlat);
        out_t e, fin;
        bit   ok;
        int   kind;
        cur_op = op; cur_f3 = f3;
        add_cyc(1'b1, rb(), rb(), zo(ST_IDLE));
        fin = '0; fin.irl = 1'b1; fin.pcw = 1'b1;
        wait_mem(ST_FETCH, 1'b0, 1'b0, flat, fin, ok);
        if (!ok) return;
        add_cyc(rb(), rb(), rb(), zo(ST_DECODE));
        case (op)
            7'b0110011: kind = 1;
            7'b0010011: kind = 2;
            7'b0000011: kind = 3;
            7'b0100011: kind = 4;
            7'b1100011: kind = 5;
            7'b1101111: kind = 6;
            default:    kind = 0;
        endcase
        if (kind == 0) begin
            add_trap(CAUSE_ILLEGAL);
            return;
        end
        if (kind != 6) begin
            e = zo(ST_EXEC);
            if (kind == 1 || kind == 2) begin
                e.alus = (kind == 2);
                e.aop  = f3;
            end else if (kind == 3 || kind == 4) begin
                e.alus = 1'b1;
            end else begin
                e.aop = 3'b001;
                e.done = 1'b1;
                e.pcw = bt;
                e.pcs = bt ? 2'd1 : 2'd0;
            end
            add_cyc(rb(), rb(), bt, e);
            if (kind == 5) return;
        end
        if (kind == 3 || kind == 4) begin
            fin = '0;
            fin.done = (kind == 4);
            wait_mem(ST_MEM, kind == 4, 1'b1, mlat, fin, ok);
            if (!ok || kind == 4) return;
        end
        e = zo(ST_WB);
        e.rw = 1'b1;
        e.done = 1'b1;
        e.wbs = (kind == 3) ? 2'd1 : (kind == 6) ? 2'd2 : 2'd0;
        if (kind == 6) begin
            e.pcw = 1'b1;
            e.pcs = 2'd2;
        end
        add_cyc(rb(), rb(), rb(), e);
    endtask

    task automatic run_trace(output int evt, output logic trp, output logic [1:0] cause,
                             output int ndone);
        evt = 0; ndone = 0; trp = 1'b0; cause = 2'd0;
        foreach (tq[k]) begin
            run = tq[k].run; mem_ready = tq[k].rdy; branch_taken = tq[k].bt;
            opcode = tq[k].op; funct3 = tq[k].f3;
            @(negedge clk);
            check_out("trace", k, dut_out, tq[k].exp);
            if (instr_done) ndone++;
            if (evt == 0 && (instr_done || trap)) evt = k + 1;
            trp = trap; cause = trap_cause;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        #2;
        check_out("reset", 0, dut_out, zo(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        tq.delete();
    endtask

    initial begin
        int         evt, nd, ninstr;
        logic       lt;
        logic [1:0] lc;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        opcode = '0; funct3 = '0; cur_op = '0; cur_f3 = '0;

        //             op            f3      bt    flat mlat len trp  cause
        tbl[0]  = '{7'b0110011, 3'b000, 1'b0, 0,   0,   5,  1'b0, 2'd0};
        tbl[1]  = '{7'b0110011, 3'b110, 1'b0, 0,   0,   5,  1'b0, 2'd0};
        tbl[2]  = '{7'b0010011, 3'b111, 1'b0, 0,   0,   5,  1'b0, 2'd0};
        tbl[3]  = '{7'b0000011, 3'b010, 1'b0, 0,   0,   6,  1'b0, 2'd0};
        tbl[4]  = '{7'b0000011, 3'b010, 1'b0, 0,   3,   9,  1'b0, 2'd0};
        tbl[5]  = '{7'b0100011, 3'b010, 1'b0, 0,   0,   5,  1'b0, 2'd0};
        tbl[6]  = '{7'b1100011, 3'b000, 1'b1, 0,   0,   4,  1'b0, 2'd0};
        tbl[7]  = '{7'b1100011, 3'b001, 1'b0, 0,   0,   4,  1'b0, 2'd0};
        tbl[8]  = '{7'b1101111, 3'b000, 1'b0, 0,   0,   4,  1'b0, 2'd0};
        tbl[9]  = '{7'b0110011, 3'b000, 1'b0, 2,   0,   7,  1'b0, 2'd0};
        tbl[10] = '{7'b0110011, 3'b100, 1'b0, 15,  0,   20, 1'b0, 2'd0};
        tbl[11] = '{7'b0100011, 3'b000, 1'b0, 0,   15,  20, 1'b0, 2'd0};
        tbl[12] = '{7'b1111111, 3'b000, 1'b0, 0,   0,   4,  1'b1, 2'd1};
        tbl[13] = '{7'b0110011, 3'b000, 1'b0, 16,  0,   18, 1'b1, 2'd2};
        tbl[14] = '{7'b0000011, 3'b000, 1'b0, 0,   16,  21, 1'b1, 2'd2};

        for (int r = 0; r < 15; r++) begin
            do_reset();
            add_instr(tbl[r].op, tbl[r].f3, tbl[r].bt, tbl[r].flat, tbl[r].mlat);
            run_trace(evt, lt, lc, nd);
            check_int($sformatf("vec%0d_len", r), evt, tbl[r].len);
            check_int($sformatf("vec%0d_trap", r), int'(lt), int'(tbl[r].trp));
            check_int($sformatf("vec%0d_cause", r), int'(lc), int'(tbl[r].cause));
            check_int($sformatf("vec%0d_done", r), nd, tbl[r].trp ? 0 : 1);
        end

        // STORE immediately followed by a taken BRANCH.
        do_reset();
        add_instr(7'b0100011, 3'b001, 1'b0, 1, 2);
        add_instr(7'b1100011, 3'b000, 1'b1, 0, 0);
        run_trace(evt, lt, lc, nd);
        check_int("store_branch_done", nd, 2);

        // Asynchronous reset in the middle of a fetch drops the request at once.
        do_reset();
        run = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_int("midfetch_req", int'(mem_req), 1);
        #1;
        rst = 1'b1;
        #1;
        check_int("midfetch_req_drop", int'(mem_req), 0);
        check_int("midfetch_state", int'(state_o), int'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random back-to-back instruction stream with idle gaps and memory waits.
        do_reset();
        ninstr = 0;
        for (int i = 0; i < 40; i++) begin
            logic [6:0] ops [6];
            int pick, fl, ml;
            ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
            ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
            add_gap($urandom_range(0, 2));
            pick = $urandom_range(0, 5);
            fl = $urandom_range(0, 9);
            fl = (fl < 6) ? 0 : (fl < 9) ? $urandom_range(1, 4) : TB_TIMEOUT;
            ml = $urandom_range(0, 9);
            ml = (ml < 6) ? 0 : (ml < 9) ? $urandom_range(1, 4) : TB_TIMEOUT;
            add_instr(ops[pick], 3'($urandom_range(0, 7)), rb(), fl, ml);
            ninstr++;
        end
        run_trace(evt, lt, lc, nd);
        check_int("random_retired", nd, ninstr);
        check_int("random_no_trap", int'(lt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
